// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and its neighbours (grf, forwarding mux).
//
// Contents:
//   XLEN / DLEN       - 32-bit register width and 64-bit product width
//   MdMultCyclesDef   - default mult/multu/madd/maddu latency
//   MdDivCyclesDef    - default div/divu latency
//   md_op_e           - MDOp encodings MD_MULT..MD_MADDU
//   is_mult_op()      - ops that take the multiply latency
//   is_div_op()       - ops that take the divide latency
//
// Optional feature macro: MDU_MADD_EN (enables MD_MADD / MD_MADDU).
package mdu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned DLEN = 64;

  localparam int unsigned MdMultCyclesDef = 5;
  localparam int unsigned MdDivCyclesDef  = 10;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5,
    MD_MADD  = 3'd6,
    MD_MADDU = 3'd7
  } md_op_e;

  function automatic logic is_mult_op(input md_op_e op);
    logic r;
    r = (op == MD_MULT) || (op == MD_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == MD_MADD) || (op == MD_MADDU);
`endif
    return r;
  endfunction

  function automatic logic is_div_op(input md_op_e op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational result unit of the multiply/divide unit.
//
// Computes the {HI,LO} value an operation will commit, plus whether it commits at all
// (divide by zero commits nothing). A single divider serves div and divu by working on
// magnitudes and fixing the signs afterwards.
//
// Ports:
//   op        - decoded MDOp
//   a, b      - operands rs / rt
//   hi_cur    - current HI (only with MDU_MADD_EN)
//   lo_cur    - current LO (only with MDU_MADD_EN)
//   res_hi    - result for HI
//   res_lo    - result for LO
//   res_write - result should be written to HI/LO on completion
//
// Optional feature macro: MDU_MADD_EN (adds the madd/maddu accumulator).
module mdu_calc
  import mdu_pkg::*;
(
  input  md_op_e            op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
`ifdef MDU_MADD_EN
  input  logic [XLEN-1:0]   hi_cur,
  input  logic [XLEN-1:0]   lo_cur,
`endif
  output logic [XLEN-1:0]   res_hi,
  output logic [XLEN-1:0]   res_lo,
  output logic              res_write
);

  logic [DLEN-1:0] prod_s;
  logic [DLEN-1:0] prod_u;

  logic            div_signed;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic [XLEN-1:0] dvd;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] q_mag;
  logic [XLEN-1:0] r_mag;
  logic [XLEN-1:0] quot;
  logic [XLEN-1:0] rem;

  // Sign-extend to 64 bits so a plain 64-bit multiply gives the signed product mod 2^64.
  assign prod_s = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
  assign prod_u = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};

  assign div_signed = (op == MD_DIV);
  assign a_neg      = div_signed & a[XLEN-1];
  assign b_neg      = div_signed & b[XLEN-1];
  assign b_zero     = (b == '0);

  // Divisor forced to 1 on B==0 only to keep the divider defined; that result is discarded.
  assign dvd   = a_neg ? (~a + 32'd1) : a;
  assign dvs   = b_zero ? 32'd1 : (b_neg ? (~b + 32'd1) : b);
  assign q_mag = dvd / dvs;
  assign r_mag = dvd % dvs;

  // Quotient truncates toward zero; remainder takes the dividend's sign.
  // 0x80000000 / -1: magnitude 0x80000000, negated back to 0x80000000.
  assign quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem  = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_hi    = '0;
    res_lo    = '0;
    res_write = 1'b0;
    unique case (op)
      MD_MULT: begin
        {res_hi, res_lo} = prod_s;
        res_write        = 1'b1;
      end
      MD_MULTU: begin
        {res_hi, res_lo} = prod_u;
        res_write        = 1'b1;
      end
      MD_DIV, MD_DIVU: begin
        res_lo    = quot;
        res_hi    = rem;
        res_write = !b_zero;
      end
`ifdef MDU_MADD_EN
      MD_MADD: begin
        {res_hi, res_lo} = {hi_cur, lo_cur} + prod_s;
        res_write        = 1'b1;
      end
      MD_MADDU: begin
        {res_hi, res_lo} = {hi_cur, lo_cur} + prod_u;
        res_write        = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit (EX stage). Owns the architectural HI/LO registers and models
// mult/div latency with a registered Busy flag that decode hazard logic stalls on.
//
// Parameters:
//   MULT_CYCLES - cycles Busy stays high for mult/multu/madd/maddu (>=1)
//   DIV_CYCLES  - cycles Busy stays high for div/divu (>=1)
//
// Ports:
//   Clk    - clock, rising edge
//   Reset  - synchronous active-high reset; aborts any in-flight operation
//   Start  - one-cycle pulse launching MDOp (ignored while Busy)
//   MDOp   - operation, see mdu_pkg::md_op_e
//   A, B   - forwarded rs / rt operands
//   Busy   - high while a mult/div is in flight
//   HI, LO - architectural HI/LO registers
//
// Optional feature macro: MDU_MADD_EN (accepts MDOp 6 madd / 7 maddu).
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MdMultCyclesDef,
  parameter int unsigned DIV_CYCLES  = MdDivCyclesDef
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [2:0]      MDOp,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  output logic            Busy,
  output logic [XLEN-1:0] HI,
  output logic [XLEN-1:0] LO
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  md_op_e op;

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            busy_q;
  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] pend_hi_q;
  logic [XLEN-1:0] pend_lo_q;
  logic            pend_wr_q;

  logic [XLEN-1:0] calc_hi;
  logic [XLEN-1:0] calc_lo;
  logic            calc_write;

  assign op = md_op_e'(MDOp);

  // madd/maddu are evaluated against HI/LO at launch; since nothing can write HI/LO while
  // Busy, that equals the value at completion.
  mdu_calc u_calc (
    .op        (op),
    .a         (A),
    .b         (B),
`ifdef MDU_MADD_EN
    .hi_cur    (hi_q),
    .lo_cur    (lo_q),
`endif
    .res_hi    (calc_hi),
    .res_lo    (calc_lo),
    .res_write (calc_write)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else if (busy_q) begin
      // Start is ignored here, including on the edge where Busy drops.
      if (cnt_q == CntW'(1)) begin
        busy_q    <= 1'b0;
        cnt_q     <= '0;
        pend_wr_q <= 1'b0;
        if (pend_wr_q) begin
          hi_q <= pend_hi_q;
          lo_q <= pend_lo_q;
        end
      end else begin
        cnt_q <= cnt_q - CntW'(1);
      end
    end else if (Start) begin
      if (is_mult_op(op) || is_div_op(op)) begin
        pend_hi_q <= calc_hi;
        pend_lo_q <= calc_lo;
        pend_wr_q <= calc_write;
        busy_q    <= 1'b1;
        cnt_q     <= is_mult_op(op) ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
      end else if (op == MD_MTHI) begin
        hi_q <= A;
      end else if (op == MD_MTLO) begin
        lo_q <= A;
      end
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu (MULT_CYCLES=5, DIV_CYCLES=10).
// Inputs change 1ns after a rising edge; outputs are sampled at the same point.
module tb_mdu;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic [2:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  int tests = 0;
  int fails = 0;

  // Expected architectural HI/LO
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always #5 Clk = ~Clk;

  mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .MDOp  (MDOp),
    .A     (A),
    .B     (B),
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic busy_exp);
    chk({tag, " busy"}, {31'b0, Busy}, {31'b0, busy_exp});
    chk({tag, " hi"}, HI, m_hi);
    chk({tag, " lo"}, LO, m_lo);
  endtask

  // Launch a long op, check Busy and unchanged HI/LO for n cycles, then the result.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] nhi, input logic [31:0] nlo);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    B     = b;
    step();
    Start = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk_state($sformatf("%s cyc%0d", tag, i + 1), 1'b1);
      step();
    end
    m_hi = nhi;
    m_lo = nlo;
    chk_state({tag, " done"}, 1'b0);
  endtask

  task automatic move(input string tag, input logic [2:0] op, input logic [31:0] a);
    Start = 1'b1;
    MDOp  = op;
    A     = a;
    step();
    Start = 1'b0;
    if (op == 3'd4) m_hi = a;
    else            m_lo = a;
    chk_state(tag, 1'b0);
  endtask

  initial begin
    Reset = 1'b1;
    Start = 1'b0;
    MDOp  = 3'd0;
    A     = 32'h0;
    B     = 32'h0;
    step();
    step();
    Reset = 1'b0;
    chk_state("reset", 1'b0);

    // mult -2 * 3 = -6
    run_op("mult", 3'd0, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    // divu 7 / 2
    run_op("divu", 3'd3, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    // div -7 / 2 -> q=-3, r=-1
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // div overflow case
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);
    // mthi is zero latency
    move("mthi", 3'd4, 32'h1234_5678);
    // divide by zero: full latency, no update
    run_op("div_zero", 3'd2, 32'd5, 32'd0, 10, m_hi, m_lo);

    // multu with Start pulses while Busy, including on the edge Busy drops
    move("mtlo", 3'd5, 32'hAAAA_5555);
    Start = 1'b1;
    MDOp  = 3'd1;
    A     = 32'hFFFF_FFFF;
    B     = 32'hFFFF_FFFF;
    step();
    Start = 1'b0;
    chk_state("multu cyc1", 1'b1);
    step();
    Start = 1'b1;
    MDOp  = 3'd5;
    A     = 32'h0000_0001;
    chk_state("multu cyc2", 1'b1);
    step();
    Start = 1'b0;
    chk_state("multu cyc3 mtlo ignored", 1'b1);
    step();
    chk_state("multu cyc4", 1'b1);
    step();
    chk_state("multu cyc5", 1'b1);
    Start = 1'b1;
    MDOp  = 3'd4;
    A     = 32'hDEAD_BEEF;
    step();
    Start = 1'b0;
    m_hi  = 32'hFFFF_FFFE;
    m_lo  = 32'h0000_0001;
    chk_state("multu done", 1'b0);
    step();
    chk_state("mthi on drop edge ignored", 1'b0);

    // signed mult: (-2^31)^2 = 2^62
    run_op("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0);

`ifdef MDU_MADD_EN
    move("mthi 0", 3'd4, 32'h0);
    move("mtlo ff", 3'd5, 32'hFFFF_FFFF);
    run_op("maddu", 3'd7, 32'd1, 32'd1, 5, 32'd1, 32'd0);
    run_op("madd", 3'd6, 32'hFFFF_FFFF, 32'd1, 5, 32'd0, 32'hFFFF_FFFF);
`else
    Start = 1'b1;
    MDOp  = 3'd6;
    A     = 32'd5;
    B     = 32'd5;
    step();
    Start = 1'b0;
    chk_state("op6 ignored", 1'b0);
    step();
    chk_state("op6 ignored next", 1'b0);
`endif

    // Reset on cycle 4 of a divide aborts it
    Start = 1'b1;
    MDOp  = 3'd2;
    A     = 32'd100;
    B     = 32'd7;
    step();
    Start = 1'b0;
    step();
    step();
    step();
    chk_state("abort cyc4", 1'b1);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    m_hi  = 32'h0;
    m_lo  = 32'h0;
    chk_state("abort reset", 1'b0);
    repeat (12) step();
    chk_state("abort no update", 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
